// File: rtl/fsm_pkg.sv
// Shared definitions for the pattern serializer and the sequence-detector benches:
// state encoding, default geometry and the canonical "101" test pattern.
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam int WIDTH_DEF = 3;
    localparam int CNT_W_DEF = 4;
    localparam int GAP_W_DEF = 2;

    localparam logic [2:0] DETECT_101 = 3'b101;

endpackage

// File: rtl/pattern_serializer.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit word out MSB-first,
// repeat_n times, with an optional idle gap between repetitions.
module pattern_serializer
    import fsm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_e           state_r, state_s;
    logic [WIDTH-1:0] pat_r, pat_s;
    logic [IDX_W-1:0] bit_idx_r, bit_idx_s;
    logic [CNT_W-1:0] rep_left_r, rep_left_s;
    logic [GAP_W-1:0] gap_r, gap_s;
    logic [GAP_W-1:0] gap_cnt_r, gap_cnt_s;
    logic             out_r, out_s;
    logic             out_valid_r, out_valid_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;

    // Next-state, counter and output decode; outputs derive from the next state so they can be registered.
    always_comb begin
        state_s    = state_r;
        pat_s      = pat_r;
        bit_idx_s  = bit_idx_r;
        rep_left_s = rep_left_r;
        gap_s      = gap_r;
        gap_cnt_s  = gap_cnt_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    pat_s      = pattern;
                    rep_left_s = repeat_n;
                    gap_s      = gap;
                    bit_idx_s  = IDX_LAST;
                    if (repeat_n == '0) begin
                        state_s = DONE;
                    end else begin
                        state_s = SEND;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (bit_idx_r == '0) begin
                    // rep_left is tested before decrementing so a maximal count never wraps
                    if (rep_left_r == CNT_W'(1)) begin
                        rep_left_s = '0;
                        state_s    = DONE;
                    end else begin
                        rep_left_s = rep_left_r - CNT_W'(1);
                        bit_idx_s  = IDX_LAST;
                        if (gap_r == '0) begin
                            state_s = SEND;
                        end else begin
                            gap_cnt_s = gap_r;
                            state_s   = GAP;
                        end
                    end
                end else begin
                    bit_idx_s = bit_idx_r - IDX_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt_r <= GAP_W'(1)) begin
                    gap_cnt_s = '0;
                    bit_idx_s = IDX_LAST;
                    state_s   = SEND;
                end else begin
                    gap_cnt_s = gap_cnt_r - GAP_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s    = IDLE;
                pat_s      = '0;
                bit_idx_s  = '0;
                rep_left_s = '0;
                gap_s      = '0;
                gap_cnt_s  = '0;
            end
        endcase

        if (state_s == SEND) begin
            out_s       = pat_s[bit_idx_s];
            out_valid_s = 1'b1;
        end else begin
            out_s       = 1'b0;
            out_valid_s = 1'b0;
        end
        busy_s = (state_s != IDLE);
        done_s = (state_s == DONE);
    end

    // State, counters, latched inputs and registered outputs; reset aborts at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            pat_r       <= '0;
            bit_idx_r   <= '0;
            rep_left_r  <= '0;
            gap_r       <= '0;
            gap_cnt_r   <= '0;
            out_r       <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            pat_r       <= pat_s;
            bit_idx_r   <= bit_idx_s;
            rep_left_r  <= rep_left_s;
            gap_r       <= gap_s;
            gap_cnt_r   <= gap_cnt_s;
            out_r       <= out_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed self-checking bench for pattern_serializer; cycle n is observed 1 time unit after edge n.
module tb_pattern_serializer;
    import fsm_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] pattern;
    logic [3:0] repeat_n;
    logic [1:0] gap;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int det   = 0;
    logic [2:0] det_sh = 3'b000;
    int det_len = 0;

    pattern_serializer #(.WIDTH(3), .CNT_W(4), .GAP_W(2)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
        .repeat_n(repeat_n), .gap(gap), .out(out), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (out_valid === 1'b1) begin
            det_sh = {det_sh[1:0], out};
            det_len++;
            if (det_len >= 3 && det_sh == DETECT_101) det++;
        end
    endtask

    task automatic det_clear();
        det = 0;
        det_sh = 3'b000;
        det_len = 0;
    endtask

    // advance one edge and check all four outputs
    task automatic cyc(input string tag, input logic o, input logic v, input logic b, input logic d);
        tick();
        chk({tag, ".out"}, {31'd0, out}, {31'd0, o});
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
    endtask

    task automatic go(input logic [2:0] p, input logic [3:0] r, input logic [1:0] g);
        pattern = p; repeat_n = r; gap = g; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int vcnt;
        int dcyc;
        reset = 1'b1; start = 1'b0; pattern = 3'b000; repeat_n = 4'd0; gap = 2'd0;
        #1;
        chk("rst.out", {31'd0, out}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // single repetition; inputs changed after the start edge must not matter
        go(DETECT_101, 4'd1, 2'd0);
        pattern = 3'b010; repeat_n = 4'd7; gap = 2'd3;
        chk("t1.c1.out", {31'd0, out}, 32'd1);
        chk("t1.c1.valid", {31'd0, out_valid}, 32'd1);
        chk("t1.c1.busy", {31'd0, busy}, 32'd1);
        cyc("t1.c2", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("t1.c3", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("t1.c4", 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("t1.c5", 1'b0, 1'b0, 1'b0, 1'b0);

        // two back-to-back repetitions, chained detector sees two hits
        det_clear();
        go(DETECT_101, 4'd2, 2'd0);
        det_sh = {det_sh[1:0], out}; det_len = 1;
        chk("t2.c1.out", {31'd0, out}, 32'd1);
        cyc("t2.c2", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("t2.c3", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("t2.c4", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("t2.c5", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("t2.c6", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("t2.c7", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t2.det", det, 32'd2);
        cyc("t2.c8", 1'b0, 1'b0, 1'b0, 1'b0);

        // two repetitions with a two-cycle gap
        go(DETECT_101, 4'd2, 2'd2);
        chk("t3.c1.out", {31'd0, out}, 32'd1);
        cyc("t3.c2", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("t3.c3", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("t3.c4", 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("t3.c5", 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("t3.c6", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("t3.c7", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("t3.c8", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("t3.c9", 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("t3.c10", 1'b0, 1'b0, 1'b0, 1'b0);

        // zero repetitions: straight to DONE
        go(3'b111, 4'd0, 2'd1);
        chk("t4.c1.valid", {31'd0, out_valid}, 32'd0);
        chk("t4.c1.done", {31'd0, done}, 32'd1);
        chk("t4.c1.busy", {31'd0, busy}, 32'd1);
        cyc("t4.c2", 1'b0, 1'b0, 1'b0, 1'b0);

        // start re-asserted while busy and held through DONE is ignored
        go(DETECT_101, 4'd1, 2'd0);
        chk("t5.c1.out", {31'd0, out}, 32'd1);
        start = 1'b1; pattern = 3'b010; repeat_n = 4'd3;
        cyc("t5.c2", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("t5.c3", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("t5.c4", 1'b0, 1'b0, 1'b1, 1'b1);
        start = 1'b0;
        cyc("t5.c5", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("t5.c6", 1'b0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset during the second bit aborts with no done
        go(DETECT_101, 4'd3, 2'd1);
        tick();
        chk("t6.c2.valid", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6.rst.out", {31'd0, out}, 32'd0);
        chk("t6.rst.valid", {31'd0, out_valid}, 32'd0);
        chk("t6.rst.busy", {31'd0, busy}, 32'd0);
        chk("t6.rst.done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        cyc("t6.post1", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("t6.post2", 1'b0, 1'b0, 1'b0, 1'b0);
        go(3'b110, 4'd1, 2'd0);
        chk("t6.new.c1.out", {31'd0, out}, 32'd1);
        cyc("t6.new.c2", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("t6.new.c3", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("t6.new.c4", 1'b0, 1'b0, 1'b1, 1'b1);

        // maximum repeat and gap: 15*3 + 14*3 = 87 busy cycles, done at cycle 88
        tick();
        go(DETECT_101, 4'd15, 2'd3);
        vcnt = (out_valid === 1'b1) ? 1 : 0;
        dcyc = 0;
        for (int c = 2; c <= 200 && dcyc == 0; c++) begin
            tick();
            if (out_valid === 1'b1) vcnt++;
            if (done === 1'b1) dcyc = c;
        end
        chk("tmax.valid_cycles", vcnt, 32'd45);
        chk("tmax.done_cycle", dcyc, 32'd88);
        cyc("tmax.after", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
- Serial pattern transmitter for the bit-stream side of the sequence-detector subsystem.
- Latches a WIDTH-bit pattern, a repeat count and an inter-pattern gap length.
- Shifts the pattern out MSB-first, one bit per clock, for repeat_n repetitions, with registered Moore-style outputs.
- Drives detector test streams. Example: pattern 3'b101 produces the stream a "101" detector fires on.

Parameters:
WIDTH, 3, pattern length in bits (>=2)
CNT_W, 4, width of repetition count
GAP_W, 2, width of inter-repetition idle-gap count

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a transmission; sampled only in IDLE
pattern  input  WIDTH  pattern word, bit WIDTH-1 is sent first
repeat_n  input  CNT_W  number of repetitions; 0 means send nothing
gap  input  GAP_W  idle cycles inserted between repetitions
out  output  1  serial data bit
out_valid  output  1  out carries a pattern bit this cycle
busy  output  1  transmission in progress; start is ignored
done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- Reset values: state=IDLE; out=0, out_valid=0, busy=0, done=0; all counters and latched registers 0.
- Reset asserted mid-transmission aborts immediately. No done pulse is generated.
- All outputs are registered. They are decoded from state and registers only, never from inputs.
- IDLE:
  - On an edge with start=1: latch pattern, repeat_n and gap.
  - If repeat_n=0, go to DONE.
  - Otherwise go to SEND with bit_idx=WIDTH-1 and rep_left=repeat_n.
- Latency: the first bit appears in the cycle immediately after the start-sampling edge. If start is sampled at edge k, bit i (MSB = i=0) is on out during cycle k+1+i.
- SEND:
  - out = pat_reg[bit_idx], out_valid=1, busy=1.
  - Each edge decrements bit_idx.
  - At bit_idx=0, decrement rep_left:
    - rep_left was 1: go to DONE.
    - else gap=0: reload bit_idx=WIDTH-1 and stay in SEND (back-to-back, no bubble).
    - else: go to GAP with gap_cnt=gap.
- GAP:
  - out=0, out_valid=0, busy=1.
  - gap_cnt decrements each edge. Exactly `gap` cycles are spent in GAP.
  - When gap_cnt reaches 1, the next edge goes to SEND with bit_idx=WIDTH-1.
- DONE:
  - done=1, busy=1, out=0, out_valid=0, for exactly one cycle.
  - Unconditionally returns to IDLE.
  - start during DONE is ignored.
- start while busy has no effect. Latched registers are not updated.
- pattern, repeat_n and gap may change freely after the start edge without affecting the transfer.
- Total cycles from start edge to done, for repeat_n=R>0 and gap=G: R*WIDTH + (R-1)*G cycles of SEND/GAP, then 1 DONE cycle.
- Edge values: maximum repeat_n (2^CNT_W-1) and maximum gap must work with no counter wrap. rep_left is compared before decrement.
- Any illegal state encoding goes to IDLE with all outputs 0.

Decomposition:
- Shared package fsm_pkg holds:
  - state encoding constants: IDLE=2'b00, SEND=2'b01, GAP=2'b10, DONE=2'b11;
  - default WIDTH/CNT_W/GAP_W values;
  - the DETECT_101 = 3'b101 pattern constant, shared with the detector benches.
- Single module, no sub-module. Counters are small enough to live inline.
- Keep the state register and next-state/output logic in separate always blocks.

Test Plan:
- pattern=101, repeat_n=1, gap=0, start at edge 0 -> cycles 1-3: out=1,0,1 with out_valid=1; cycle 4: done=1; cycle 5: busy=0.
- pattern=101, repeat_n=2, gap=0 -> out_valid high for 6 contiguous cycles carrying 1,0,1,1,0,1; done at cycle 7. A chained 101 detector must pulse twice.
- pattern=101, repeat_n=2, gap=2 -> 1,0,1, then 2 cycles with out_valid=0/out=0, then 1,0,1; done at cycle 9.
- repeat_n=0, start pulse -> out_valid never asserts; done=1 in cycle 1; IDLE in cycle 2.
- start re-asserted at cycle 2 of a repeat_n=1 transfer with a different pattern -> ignored; original bits complete unchanged; exactly one done pulse.
- reset asserted asynchronously during SEND bit 1 -> out, out_valid, busy and done all 0 immediately. No done pulse follows. A fresh start after release transmits correctly.
